// File: rtl/mem_access_ctrl.sv
// Memory-access controller: validates one load/store, runs the MOV/MOC handshake with the
// asynchronous RAM, splits doublewords into two word accesses and extends byte/half loads.
module mem_access_ctrl #(
    parameter int MEM_BYTES = 512,
    parameter int TIMEOUT   = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req,
    input  logic        rw,
    input  logic [1:0]  size,
    input  logic        sign_ext,
    input  logic [31:0] addr,
    input  logic [63:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [1:0]  err_code,
    output logic [63:0] rdata,
    output logic        mem_mov,
    output logic        mem_rw,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_din,
    output logic [1:0]  mem_type,
    input  logic        mem_moc,
    input  logic [31:0] mem_dout
);

    // state   | meaning
    // IDLE    | waiting for req; request fields and check result captured here
    // SETUP   | RAM address/data/type stable, MOV low; a failed check exits to DONE
    // REQ     | MOV high, waiting for synchronized MOC to rise
    // RELEASE | MOV low, waiting for synchronized MOC to fall
    // DONE    | one-cycle done pulse
    typedef enum logic [2:0] {IDLE, SETUP, REQ, RELEASE, DONE} state_t;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(TIMEOUT - 1);

    state_t        state_q, state_d;
    logic          rw_q, sext_q, second_q, second_d;
    logic [1:0]    size_q, chk_q, chk;
    logic [31:0]   addr_q, wlo_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          moc_meta, moc_s;
    logic [63:0]   rd_buf_q, rd_buf_d;
    logic [3:0]    nbytes;
    logic [32:0]   end_addr;

    logic          busy_d, done_d, err_d, mem_mov_d, mem_rw_d;
    logic [1:0]    err_code_d, mem_type_d;
    logic [63:0]   rdata_d;
    logic [31:0]   mem_addr_d, mem_din_d;

    function automatic logic [31:0] extend(input logic [1:0] sz, input logic sx,
                                           input logic [31:0] d);
        logic [31:0] r;
        case (sz)
            2'b00:   r = sx ? {{24{d[7]}}, d[7:0]}   : {24'b0, d[7:0]};
            2'b01:   r = sx ? {{16{d[15]}}, d[15:0]} : {16'b0, d[15:0]};
            default: r = d;
        endcase
        return r;
    endfunction

    // Alignment outranks range so a misaligned access near the top reports 01.
    always_comb begin
        case (size)
            2'b00:   nbytes = 4'd1;
            2'b01:   nbytes = 4'd2;
            2'b10:   nbytes = 4'd4;
            default: nbytes = 4'd8;
        endcase
        end_addr = {1'b0, addr} + {29'b0, nbytes};
        chk = 2'b00;
        if ((size == 2'b01 && addr[0]) ||
            (size == 2'b10 && addr[1:0] != 2'b00) ||
            (size == 2'b11 && addr[2:0] != 3'b000))
            chk = 2'b01;
        else if (end_addr > 33'(MEM_BYTES))
            chk = 2'b10;
    end

    always_comb begin
        state_d    = state_q;
        second_d   = second_q;
        cnt_d      = cnt_q;
        rd_buf_d   = rd_buf_q;
        done_d     = 1'b0;
        err_d      = 1'b0;
        err_code_d = 2'b00;
        rdata_d    = rdata;
        mem_mov_d  = mem_mov;
        mem_rw_d   = mem_rw;
        mem_addr_d = mem_addr;
        mem_din_d  = mem_din;
        mem_type_d = mem_type;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d  = SETUP;
                    second_d = 1'b0;
                    if (chk == 2'b00) begin
                        mem_addr_d = addr;
                        mem_rw_d   = rw;
                        mem_type_d = (size == 2'b11) ? 2'b10 : size;
                        mem_din_d  = (size == 2'b11) ? wdata[63:32] : wdata[31:0];
                    end
                end
            end
            SETUP: begin
                if (chk_q != 2'b00) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = chk_q;
                end else begin
                    state_d   = REQ;
                    mem_mov_d = 1'b1;
                    cnt_d     = CNT_LOAD;
                end
            end
            REQ: begin
                if (moc_s) begin
                    state_d   = RELEASE;
                    mem_mov_d = 1'b0;
                    cnt_d     = CNT_LOAD;
                    if (rw_q) begin
                        if (size_q != 2'b11)
                            rd_buf_d = {32'b0, extend(size_q, sext_q, mem_dout)};
                        else if (second_q)
                            rd_buf_d[31:0] = mem_dout;
                        else
                            rd_buf_d[63:32] = mem_dout;
                    end
                end else if (cnt_q == '0) begin
                    state_d    = DONE;
                    mem_mov_d  = 1'b0;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            RELEASE: begin
                if (!moc_s) begin
                    if (size_q == 2'b11 && !second_q) begin
                        state_d    = SETUP;
                        second_d   = 1'b1;
                        mem_addr_d = addr_q + 32'd4;
                        mem_din_d  = wlo_q;
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                        if (rw_q)
                            rdata_d = rd_buf_q;
                    end
                end else if (cnt_q == '0) begin
                    state_d    = DONE;
                    done_d     = 1'b1;
                    err_d      = 1'b1;
                    err_code_d = 2'b11;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            second_q <= 1'b0;
            cnt_q    <= '0;
            rd_buf_q <= '0;
            moc_meta <= 1'b0;
            moc_s    <= 1'b0;
            rw_q     <= 1'b1;
            sext_q   <= 1'b0;
            size_q   <= 2'b00;
            chk_q    <= 2'b00;
            addr_q   <= '0;
            wlo_q    <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            err      <= 1'b0;
            err_code <= 2'b00;
            rdata    <= '0;
            mem_mov  <= 1'b0;
            mem_rw   <= 1'b1;
            mem_addr <= '0;
            mem_din  <= '0;
            mem_type <= 2'b00;
        end else begin
            state_q  <= state_d;
            second_q <= second_d;
            cnt_q    <= cnt_d;
            rd_buf_q <= rd_buf_d;
            moc_meta <= mem_moc;
            moc_s    <= moc_meta;
            if (state_q == IDLE && req) begin
                rw_q   <= rw;
                sext_q <= sign_ext;
                size_q <= size;
                chk_q  <= chk;
                addr_q <= addr;
                wlo_q  <= wdata[31:0];
            end
            busy     <= busy_d;
            done     <= done_d;
            err      <= err_d;
            err_code <= err_code_d;
            rdata    <= rdata_d;
            mem_mov  <= mem_mov_d;
            mem_rw   <= mem_rw_d;
            mem_addr <= mem_addr_d;
            mem_din  <= mem_din_d;
            mem_type <= mem_type_d;
        end
    end

endmodule
